// File: rtl/shift_ctrl.sv
// Shift-unit sequencer: iterative 1-bit-per-cycle shifter with a done pulse.
// Define SHIFT_CTRL_FAST_EN to compute the whole shift at accept with a barrel shifter.
module shift_ctrl #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [1:0]        amt_sel,
    input  logic [DATA_W-1:0] reg_B_data,
    input  logic [15:0]       immediate_data,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [AMT_W-1:0]  shamt_data,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [AMT_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_result;
    logic              r_busy;
    logic              r_done;

    logic [AMT_W-1:0]  w_amt;
    logic              w_is_shift;

    // Only the low amount bits of each source are meaningful.
    logic w_unused;
    assign w_unused = ^{reg_B_data[DATA_W-1:AMT_W], immediate_data[15:6+AMT_W],
                        immediate_data[5:0], mem_data[DATA_W-1:AMT_W]};

    always_comb begin
        w_amt = shamt_data;
        unique case (amt_sel)
            2'b00: w_amt = reg_B_data[AMT_W-1:0];
            2'b01: w_amt = immediate_data[6+AMT_W-1:6];
            2'b10: w_amt = mem_data[AMT_W-1:0];
            2'b11: w_amt = shamt_data;
        endcase
    end

    assign w_is_shift = (op <= 3'b100);

`ifdef SHIFT_CTRL_FAST_EN
    logic w_unused_fast;
    assign w_unused_fast = ^{r_op, r_cnt, w_is_shift};

    function automatic logic [DATA_W-1:0] f_barrel(
        input logic [2:0]        i_op,
        input logic [DATA_W-1:0] i_v,
        input logic [AMT_W-1:0]  i_n
    );
        logic [2*DATA_W-1:0] w_dbl;
        w_dbl = '0;
        f_barrel = i_v;
        unique case (i_op)
            3'b000: f_barrel = i_v << i_n;
            3'b001: f_barrel = i_v >> i_n;
            3'b010: f_barrel = DATA_W'($signed(i_v) >>> i_n);
            3'b011: begin
                w_dbl = {i_v, i_v} << i_n;
                f_barrel = w_dbl[2*DATA_W-1:DATA_W];
            end
            3'b100: begin
                w_dbl = {i_v, i_v} >> i_n;
                f_barrel = w_dbl[DATA_W-1:0];
            end
            default: f_barrel = i_v;
        endcase
    endfunction
`endif

    function automatic logic [DATA_W-1:0] f_step(
        input logic [2:0]        i_op,
        input logic [DATA_W-1:0] i_v
    );
        f_step = i_v;
        unique case (i_op)
            3'b000: f_step = {i_v[DATA_W-2:0], 1'b0};
            3'b001: f_step = {1'b0, i_v[DATA_W-1:1]};
            3'b010: f_step = {i_v[DATA_W-1], i_v[DATA_W-1:1]};
            3'b011: f_step = {i_v[DATA_W-2:0], i_v[DATA_W-1]};
            3'b100: f_step = {i_v[0], i_v[DATA_W-1:1]};
            default: f_step = i_v;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= 3'b000;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op <= op;
`ifdef SHIFT_CTRL_FAST_EN
                        r_result <= f_barrel(op, data_in, w_amt);
                        r_cnt    <= '0;
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
`else
                        r_result <= data_in;
                        r_cnt    <= w_amt;
                        if (w_is_shift && (w_amt != '0)) begin
                            r_state <= S_SHIFT;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
`endif
                    end
                end
                S_SHIFT: begin
                    r_result <= f_step(r_op, r_result);
                    r_cnt    <= r_cnt - AMT_W'(1);
                    if (r_cnt == AMT_W'(1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule
